// File: rtl/bsg_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_reg_bank                                                  |
// | Purpose  : Memory-mapped register bank for the BSG bus slave. NUM_REGS   |
// |            registers of DATA_WIDTH bits sit at consecutive addresses     |
// |            starting at BASE_ADDR. A transfer is an address beat, then a  |
// |            data beat, then a one-cycle response. All register contents   |
// |            are driven in parallel on regs_out.                           |
// | Ports    : SYS_CLK    - clock, all logic on posedge                      |
// |            rst        - synchronous active-high reset                    |
// |            valid      - master beat valid                                |
// |            write      - 1=write / 0=read, sampled on the address beat    |
// |            addr_in    - register address, sampled on the address beat    |
// |            data_in    - write data, sampled on the data beat             |
// |            ready      - slave accepts a beat this cycle                  |
// |            resp_valid - one-cycle response strobe                        |
// |            resp_err   - address error, qualified by resp_valid           |
// |            data_out   - response data, held between responses            |
// |            regs_out   - reg i at [i*DATA_WIDTH +: DATA_WIDTH]            |
// | Macro    : BSG_REG_ERR_EN - when defined, out-of-range transfers raise   |
// |            resp_err; otherwise resp_err is constant 0.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bsg_reg_bank #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_REGS   = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h10
) (
  input  logic                           SYS_CLK,
  input  logic                           rst,
  input  logic                           valid,
  input  logic                           write,
  input  logic [ADDR_WIDTH-1:0]          addr_in,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic                           ready,
  output logic                           resp_valid,
  output logic                           resp_err,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The window is checked one bit wider than the address so that a window
  // touching 2**ADDR_WIDTH cannot wrap and alias low addresses.
  localparam logic [ADDR_WIDTH:0] c_base  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] c_limit = (ADDR_WIDTH+1)'({1'b0, BASE_ADDR} + NUM_REGS);

`ifdef BSG_REG_ERR_EN
  localparam logic c_err_en = 1'b1;
`else
  localparam logic c_err_en = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic                    ready_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;

  logic                    w_beat;
  logic                    w_in_range;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  assign w_beat     = valid && ready_q;
  assign w_in_range = ({1'b0, addr_q} >= c_base) && ({1'b0, addr_q} < c_limit);
  assign w_offset   = addr_q - BASE_ADDR;

  // Current contents of the addressed register; 0 when outside the window.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_in_range && (w_offset == ADDR_WIDTH'(i))) begin
        w_rd_data = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_beat) state_d = S_DATA;
      S_DATA:  if (w_beat) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      data_out_q   <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      // ready is registered from the next state so it drops exactly for RESP
      ready_q      <= (state_d != S_RESP);
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;

      if ((state_q == S_IDLE) && w_beat) begin
        addr_q  <= addr_in;
        write_q <= write;
      end

      if ((state_q == S_DATA) && w_beat) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= c_err_en & ~w_in_range;
        if (!w_in_range) begin
          data_out_q <= '0;
        end else if (write_q) begin
          data_out_q <= data_in;
        end else begin
          data_out_q <= w_rd_data;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
          if (write_q && w_in_range && (w_offset == ADDR_WIDTH'(i))) begin
            regs_q[i] <= data_in;
          end
        end
      end
    end
  end

  assign ready      = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign data_out   = data_out_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bsg_reg_bank                                               |
// | Purpose  : Self-checking bench for bsg_reg_bank. Instance 0 uses the     |
// |            default window (0x10, 3 regs); instance 1 uses a window at    |
// |            0xFE with 4 regs that touches the top of the address space.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bsg_reg_bank;

`ifdef BSG_REG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       vld [2];
  logic       wr  [2];
  logic [7:0] ad  [2];
  logic [7:0] di  [2];
  logic       rdy [2];
  logic       rv  [2];
  logic       re  [2];
  logic [7:0] dout[2];
  logic [23:0] ro0;
  logic [31:0] ro1;

  int checks = 0;
  int errors = 0;

  // Reference register images
  logic [7:0] m0 [3];
  logic [7:0] m1 [4];

  bsg_reg_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(3), .BASE_ADDR(8'h10)) u_dut0 (
    .SYS_CLK(clk), .rst(rst), .valid(vld[0]), .write(wr[0]), .addr_in(ad[0]),
    .data_in(di[0]), .ready(rdy[0]), .resp_valid(rv[0]), .resp_err(re[0]),
    .data_out(dout[0]), .regs_out(ro0));

  bsg_reg_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .BASE_ADDR(8'hFE)) u_dut1 (
    .SYS_CLK(clk), .rst(rst), .valid(vld[1]), .write(wr[1]), .addr_in(ad[1]),
    .data_in(di[1]), .ready(rdy[1]), .resp_valid(rv[1]), .resp_err(re[1]),
    .data_out(dout[1]), .regs_out(ro1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int base_of(input int d);
    return (d == 1) ? 254 : 16;
  endfunction

  function automatic int nregs_of(input int d);
    return (d == 1) ? 4 : 3;
  endfunction

  function automatic logic [31:0] model_regs(input int d);
    if (d == 1) return {m1[3], m1[2], m1[1], m1[0]};
    return {8'h00, m0[2], m0[1], m0[0]};
  endfunction

  function automatic logic [31:0] dut_regs(input int d);
    if (d == 1) return ro1;
    return {8'h00, ro0};
  endfunction

  task automatic model_clear();
    foreach (m0[i]) m0[i] = 8'h00;
    foreach (m1[i]) m1[i] = 8'h00;
  endtask

  // Plain-arithmetic view of an access: window test on integers, array write.
  task automatic model_access(input int d, input bit w, input logic [7:0] a,
                              input logic [7:0] dat, output logic [7:0] ed, output bit ee);
    int ai  = int'(a);
    bit hit = (ai >= base_of(d)) && (ai < base_of(d) + nregs_of(d));
    int idx = ai - base_of(d);
    ed = 8'h00;
    ee = ERR_EN && !hit;
    if (hit) begin
      if (w) begin
        if (d == 1) m1[idx] = dat; else m0[idx] = dat;
      end
      ed = (d == 1) ? m1[idx] : m0[idx];
    end
  endtask

  // One full transfer, checking every cycle of the handshake.
  task automatic xfer(input int d, input bit w, input logic [7:0] a, input logic [7:0] dat,
                      input string tag, output logic [7:0] got_d, output bit got_e);
    logic [7:0] ed;
    bit         ee;
    int         n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy_addr"}, 32'(rdy[d]), 32'd1);
    vld[d] = 1'b1; wr[d] = w; ad[d] = a; di[d] = 8'($urandom);
    @(posedge clk); #1;
    // write/addr must only be sampled on the address beat
    wr[d] = 1'($urandom); ad[d] = 8'($urandom); di[d] = dat;
    @(negedge clk);
    chk({tag, "_rdy_data"}, 32'(rdy[d]), 32'd1);
    chk({tag, "_rv_data"}, 32'(rv[d]), 32'd0);
    @(posedge clk); #1;
    vld[d] = 1'b0; di[d] = 8'($urandom);
    model_access(d, w, a, dat, ed, ee);
    @(negedge clk);
    chk({tag, "_rv_resp"}, 32'(rv[d]), 32'd1);
    chk({tag, "_rdy_resp"}, 32'(rdy[d]), 32'd0);
    chk({tag, "_dout"}, 32'(dout[d]), 32'(ed));
    chk({tag, "_err"}, 32'(re[d]), 32'(ee));
    chk({tag, "_regs"}, dut_regs(d), model_regs(d));
    got_d = dout[d];
    got_e = re[d];
    @(negedge clk);
    chk({tag, "_rv_after"}, 32'(rv[d]), 32'd0);
    chk({tag, "_err_after"}, 32'(re[d]), 32'd0);
    chk({tag, "_dout_hold"}, 32'(dout[d]), 32'(ed));
    chk({tag, "_rdy_after"}, 32'(rdy[d]), 32'd1);
  endtask

  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] dat;
    logic [7:0] exp_d;
    bit         exp_e;
  } vec_t;

  vec_t tbl0 [8];
  vec_t tbl1 [7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] gd;
    bit         ge;

    tbl0[0] = '{1'b1, 8'h11, 8'hA5, 8'hA5, 1'b0};
    tbl0[1] = '{1'b0, 8'h11, 8'h00, 8'hA5, 1'b0};
    tbl0[2] = '{1'b1, 8'h20, 8'h3C, 8'h00, ERR_EN};
    tbl0[3] = '{1'b1, 8'h10, 8'h5A, 8'h5A, 1'b0};
    tbl0[4] = '{1'b1, 8'h12, 8'hC3, 8'hC3, 1'b0};
    tbl0[5] = '{1'b0, 8'h0F, 8'h00, 8'h00, ERR_EN};
    tbl0[6] = '{1'b1, 8'h13, 8'h77, 8'h00, ERR_EN};
    tbl0[7] = '{1'b0, 8'h12, 8'h00, 8'hC3, 1'b0};

    tbl1[0] = '{1'b1, 8'hFE, 8'h11, 8'h11, 1'b0};
    tbl1[1] = '{1'b1, 8'hFF, 8'h22, 8'h22, 1'b0};
    tbl1[2] = '{1'b1, 8'h00, 8'h33, 8'h00, ERR_EN};
    tbl1[3] = '{1'b0, 8'hFE, 8'h00, 8'h11, 1'b0};
    tbl1[4] = '{1'b0, 8'hFF, 8'h00, 8'h22, 1'b0};
    tbl1[5] = '{1'b0, 8'h00, 8'h00, 8'h00, ERR_EN};
    tbl1[6] = '{1'b1, 8'hFD, 8'h44, 8'h00, ERR_EN};

    model_clear();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; wr[d] = 1'b0; ad[d] = 8'h00; di[d] = 8'h00;
    end

    // Reset held for 3 cycles: everything quiet and zero
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 32'(rdy[0]), 32'd0);
      chk("rst_rv", 32'(rv[0]), 32'd0);
      chk("rst_err", 32'(re[0]), 32'd0);
      chk("rst_dout", 32'(dout[0]), 32'd0);
      chk("rst_regs0", dut_regs(0), 32'd0);
      chk("rst_regs1", dut_regs(1), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_first", 32'(rdy[0]), 32'd1);
    chk("rst_ready_first1", 32'(rdy[1]), 32'd1);

    // Table vectors, default window
    for (int i = 0; i < 8; i++) begin
      xfer(0, tbl0[i].w, tbl0[i].a, tbl0[i].dat, $sformatf("tbl0_%0d", i), gd, ge);
      chk($sformatf("tbl0_%0d_data", i), 32'(gd), 32'(tbl0[i].exp_d));
      chk($sformatf("tbl0_%0d_rerr", i), 32'(ge), 32'(tbl0[i].exp_e));
    end

    // Table vectors, window at the top of the address space
    for (int i = 0; i < 7; i++) begin
      xfer(1, tbl1[i].w, tbl1[i].a, tbl1[i].dat, $sformatf("tbl1_%0d", i), gd, ge);
      chk($sformatf("tbl1_%0d_data", i), 32'(gd), 32'(tbl1[i].exp_d));
      chk($sformatf("tbl1_%0d_rerr", i), 32'(ge), 32'(tbl1[i].exp_e));
    end
    chk("tbl1_no_alias_reg2", 32'(ro1[23:16]), 32'd0);

    // valid held high over three back-to-back writes
    @(negedge clk);
    vld[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      case (k % 3)
        0: begin wr[0] = 1'b1; ad[0] = 8'(8'h10 + k / 3); di[0] = 8'($urandom); end
        1: begin wr[0] = 1'b0; ad[0] = 8'($urandom); di[0] = 8'(8'hB0 + k); end
        default: begin ad[0] = 8'($urandom); di[0] = 8'($urandom); end
      endcase
      chk($sformatf("b2b_ready_%0d", k), 32'(rdy[0]), (k % 3 == 2) ? 32'd0 : 32'd1);
      chk($sformatf("b2b_rv_%0d", k), 32'(rv[0]), (k % 3 == 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    vld[0] = 1'b0;
    for (int r = 0; r < 3; r++) m0[r] = 8'(8'hB0 + 3 * r + 1);
    chk("b2b_regs", dut_regs(0), model_regs(0));

    // Reset while the write is waiting for its data beat
    @(negedge clk);
    vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 8'h10;
    @(posedge clk); #1;
    di[0] = 8'hFF; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    chk("abort_rv", 32'(rv[0]), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd0);
    chk("abort_regs", dut_regs(0), 32'd0);
    rst = 1'b0; vld[0] = 1'b0;
    @(negedge clk);
    chk("abort_rv_after", 32'(rv[0]), 32'd0);
    chk("abort_regs_after", dut_regs(0), 32'd0);
    xfer(0, 1'b1, 8'h10, 8'h69, "post_abort", gd, ge);

    // Randomised traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(8'h0E + $urandom_range(6));
      xfer(0, 1'($urandom), a, 8'($urandom), $sformatf("rnd0_%0d", i), gd, ge);
    end
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a = 8'(8'hFC + $urandom_range(7));
      xfer(1, 1'($urandom), a, 8'($urandom), $sformatf("rnd1_%0d", i), gd, ge);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
